writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Parametrised write-back stage. Selects the register-file write data from
//  NUM_SRC result sources (ALU, memory, branch-link, ...), then registers the
//  write port. A source index MEM_SRC marks the load path. That path stalls
//  the stage until the memory response arrives, or until a timeout expires.
//  Sits between execute/memory and the register file. Drives the RF write port
//  and the back-pressure to the pipeline.
// PARAMETERS
//  DATA_W    32  width of every source and of rf_wdata
//  NUM_SRC   4   number of result sources on src_data
//  SEL_W     2   width of in_sel; NUM_SRC <= 2**SEL_W
//  ADDR_W    5   destination register address width
//  MEM_SRC   1   in_sel value that selects the memory response path
//  TIMEOUT   255 max WAIT_MEM cycles before abort (1..2**16-1)
//  ZERO_REG  1   1: writes to address 0 are suppressed
// PORTS
//  clk           in   1              clock, all state on rising edge
//  rst_n         in   1              synchronous reset, active low
//  in_valid      in   1              upstream instruction valid
//  in_ready      out  1              stage can accept (combinational from state)
//  in_sel        in   SEL_W          source select
//  in_wen        in   1              instruction writes a register
//  in_rd         in   ADDR_W         destination register
//  src_data      in   NUM_SRC*DATA_W source k at [k*DATA_W +: DATA_W]
//  mem_rsp_valid in   1              memory load data valid (single-cycle pulse)
//  mem_rsp_data  in   DATA_W         memory load data
//  rf_we         out  1              RF write enable (registered)
//  rf_waddr      out  ADDR_W         RF write address (registered)
//  rf_wdata      out  DATA_W         RF write data (registered)
//  err_clr       in   1              clears sticky error flags
//  err_timeout   out  1              sticky: a load timed out
//  err_unexp_rsp out  1              sticky: mem_rsp_valid while not in WAIT_MEM
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state=IDLE, timer=0, rf_we=0, rf_waddr=0,
//   rf_wdata=0, err_*=0. in_ready=1 from the first cycle after reset.
//  Accept = in_valid & in_ready. in_ready=1 only in IDLE.
//  States: IDLE, WAIT_MEM.
//  IDLE, accept, in_sel!=MEM_SRC: next cycle rf_we=in_wen & ~(ZERO_REG & in_rd==0),
//   rf_waddr=in_rd, rf_wdata=src_data[in_sel]. Latency 1. One op per cycle.
//  in_sel>=NUM_SRC: source 0 is used (default path).
//  IDLE, accept, in_sel==MEM_SRC: latch in_rd/in_wen, timer=0, go WAIT_MEM.
//   rf_we=0 next cycle.
//  WAIT_MEM, mem_rsp_valid: next cycle rf_we=latched wen (zero-reg rule applies),
//   rf_waddr=latched rd, rf_wdata=mem_rsp_data. Return to IDLE.
//   in_ready returns to 1 in that same next cycle.
//  WAIT_MEM, no rsp: timer increments. When timer==TIMEOUT-1 and no rsp: go IDLE,
//   set err_timeout, no write. A rsp in the abort cycle wins: write, no error.
//  Accept with in_wen=0: the op is still consumed; loads still wait for rsp.
//  rf_we is a 1-cycle pulse. When rf_we=0, rf_waddr/rf_wdata hold their last value.
//  mem_rsp_valid in IDLE: ignored for data, sets err_unexp_rsp.
//  err_clr: clears both flags. A set event in the same cycle wins.
//  Reset mid-WAIT_MEM: pending load is discarded, no write; a later rsp flags
//   err_unexp_rsp.
// TESTING
//  Reset then 3 back-to-back accepts sel=0 rd=1,2,3 data A,B,C
//   -> rf_we=1 for 3 cycles, waddr 1,2,3, wdata A,B,C, each 1 cycle later.
//  Load sel=1 rd=7; rsp after 4 cycles with 0xDEADBEEF
//   -> in_ready=0 for 5 cycles; one write rd=7 0xDEADBEEF; then in_ready=1.
//  Load with no rsp, TIMEOUT=8
//   -> after 8 wait cycles state IDLE, err_timeout=1, no rf_we; err_clr -> 0.
//  sel=0 rd=0 ZERO_REG=1 -> rf_we stays 0. in_sel=3 with NUM_SRC=3
//   -> wdata=src_data[0].
//  Stray mem_rsp_valid in IDLE -> err_unexp_rsp=1, no write.
//   rst_n low during WAIT_MEM -> no write, outputs 0.

Source files
------------

// File: rtl/writeback_unit_if.sv
// ---------------------------------------------------------------------------
// writeback_unit_if
//  Bundles the write-back stage's bus signals: the upstream issue handshake,
//  the result-source vector, the memory load response and the register-file
//  write port. Clock, reset and the sticky error signals stay plain ports on
//  the stage itself.
//
//  Parameters mirror the stage: DATA_W, NUM_SRC, SEL_W, ADDR_W.
//
//  Signals
//   in_valid      upstream instruction valid
//   in_ready      stage can accept
//   in_sel        result source select
//   in_wen        instruction writes a register
//   in_rd         destination register
//   src_data      NUM_SRC packed sources, source k at [k*DATA_W +: DATA_W]
//   mem_rsp_valid memory load data valid (single-cycle pulse)
//   mem_rsp_data  memory load data
//   rf_we         register-file write enable
//   rf_waddr      register-file write address
//   rf_wdata      register-file write data
//
//  Modports
//   master  pipeline/memory/register-file side (drives requests, sees writes)
//   slave   the write-back stage itself
// ---------------------------------------------------------------------------
interface writeback_unit_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 5
);
    logic                        in_valid;
    logic                        in_ready;
    logic [SEL_W-1:0]            in_sel;
    logic                        in_wen;
    logic [ADDR_W-1:0]           in_rd;
    logic [NUM_SRC*DATA_W-1:0]   src_data;
    logic                        mem_rsp_valid;
    logic [DATA_W-1:0]           mem_rsp_data;
    logic                        rf_we;
    logic [ADDR_W-1:0]           rf_waddr;
    logic [DATA_W-1:0]           rf_wdata;

    modport master (
        output in_valid, in_sel, in_wen, in_rd, src_data,
        output mem_rsp_valid, mem_rsp_data,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, in_sel, in_wen, in_rd, src_data,
        input  mem_rsp_valid, mem_rsp_data,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
//  Write-back pipeline stage. Picks the register-file write data from one of
//  NUM_SRC result sources and registers the RF write port. The source index
//  MEM_SRC is the load path: accepting it parks the stage in WAIT_MEM until
//  the memory response arrives (then writes it) or until TIMEOUT wait cycles
//  have passed (then aborts without writing and raises err_timeout).
//
//  Ports
//   clk           clock, all state on rising edge
//   rst_n         synchronous reset, active low
//   bus           writeback_unit_if.slave: issue handshake, sources,
//                 memory response, registered RF write port
//   err_clr       clears both sticky error flags
//   err_timeout   sticky: a load timed out
//   err_unexp_rsp sticky: memory response seen while not waiting for one
// ---------------------------------------------------------------------------
module writeback_unit #(
    parameter int DATA_W   = 32,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int ADDR_W   = 5,
    parameter int MEM_SRC  = 1,
    parameter int TIMEOUT  = 255,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    writeback_unit_if.slave      bus,
    input  logic                 err_clr,
    output logic                 err_timeout,
    output logic                 err_unexp_rsp
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    localparam logic        ZERO_EN    = (ZERO_REG != 0);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    logic [0:0]        state_q,       state_d;
    logic [15:0]       timer_q,       timer_d;
    logic [ADDR_W-1:0] pend_rd_q,     pend_rd_d;
    logic              pend_wen_q,    pend_wen_d;
    logic              rf_we_q,       rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q,    rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q,    rf_wdata_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_unexp_q,   err_unexp_d;

    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic              is_mem_sel;
    logic              direct_we;
    logic              pend_we;

    // Source mux: any select that names no real source falls back to
    // source 0, so an out-of-range in_sel still produces defined data.
    always_comb begin
        sel_data = bus.src_data[DATA_W-1:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_data = bus.src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake and write-enable qualifiers. The stage only accepts in IDLE;
    // a write to register 0 is dropped when ZERO_REG is set, both for direct
    // results and for the latched destination of a pending load.
    always_comb begin
        accept     = bus.in_valid & (state_q == ST_IDLE);
        is_mem_sel = (bus.in_sel == SEL_W'(MEM_SRC));
        direct_we  = bus.in_wen & ~(ZERO_EN & (bus.in_rd == '0));
        pend_we    = pend_wen_q & ~(ZERO_EN & (pend_rd_q == '0));
    end

    // Next-state logic. rf_we defaults low so every write is a one-cycle
    // pulse; address/data only move when a write really happens, so they
    // hold their last written value otherwise. Error flags are cleared
    // first and then set, so a set event in the clearing cycle wins.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        pend_rd_d     = pend_rd_q;
        pend_wen_d    = pend_wen_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        err_timeout_d = err_clr ? 1'b0 : err_timeout_q;
        err_unexp_d   = err_clr ? 1'b0 : err_unexp_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_rsp_valid) begin
                    err_unexp_d = 1'b1;
                end
                if (accept) begin
                    if (is_mem_sel) begin
                        pend_rd_d  = bus.in_rd;
                        pend_wen_d = bus.in_wen;
                        timer_d    = '0;
                        state_d    = ST_WAIT_MEM;
                    end else begin
                        rf_we_d = direct_we;
                        if (direct_we) begin
                            rf_waddr_d = bus.in_rd;
                            rf_wdata_d = sel_data;
                        end
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rsp_valid) begin
                    rf_we_d = pend_we;
                    if (pend_we) begin
                        rf_waddr_d = pend_rd_q;
                        rf_wdata_d = bus.mem_rsp_data;
                    end
                    state_d = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset. Resetting while a
    // load is pending simply forgets it; a late response then lands in IDLE
    // and is flagged as unexpected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            pend_rd_q     <= '0;
            pend_wen_q    <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            err_timeout_q <= 1'b0;
            err_unexp_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pend_rd_q     <= pend_rd_d;
            pend_wen_q    <= pend_wen_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            err_timeout_q <= err_timeout_d;
            err_unexp_q   <= err_unexp_d;
        end
    end

    // Output wiring: in_ready comes straight from state, the write port
    // and error flags straight from their flops.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.rf_we     = rf_we_q;
        bus.rf_waddr  = rf_waddr_q;
        bus.rf_wdata  = rf_wdata_q;
        err_timeout   = err_timeout_q;
        err_unexp_rsp = err_unexp_q;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
//  Self-checking bench for writeback_unit, built with NUM_SRC=3, MEM_SRC=1,
//  TIMEOUT=8, ZERO_REG=1. Inputs are driven on the falling edge; a
//  transaction-level model (busy flag, wait-cycle count, pending load)
//  predicts the outputs, which are compared 1 ns after every rising edge.
//  Directed scenarios additionally pin hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_writeback_unit;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int ADDR_W  = 5;
    localparam int MEM_SRC = 1;
    localparam int TIMEOUT = 8;

    logic clk;
    logic rst_n;
    logic err_clr;
    logic err_timeout;
    logic err_unexp_rsp;

    int checks;
    int errors;
    int write_count;

    writeback_unit_if #(
        .DATA_W (DATA_W),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W),
        .ADDR_W (ADDR_W)
    ) wb_if ();

    writeback_unit #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W),
        .ADDR_W  (ADDR_W),
        .MEM_SRC (MEM_SRC),
        .TIMEOUT (TIMEOUT),
        .ZERO_REG(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (wb_if.slave),
        .err_clr      (err_clr),
        .err_timeout  (err_timeout),
        .err_unexp_rsp(err_unexp_rsp)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs on the falling edge so they are stable at
    // the next rising edge.
    task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] sel,
                                 input logic wen, input logic [ADDR_W-1:0] rd,
                                 input logic [NUM_SRC*DATA_W-1:0] src,
                                 input logic rspv, input logic [DATA_W-1:0] rspd,
                                 input logic clr);
        @(negedge clk);
        wb_if.in_valid      = v;
        wb_if.in_sel        = sel;
        wb_if.in_wen        = wen;
        wb_if.in_rd         = rd;
        wb_if.src_data      = src;
        wb_if.mem_rsp_valid = rspv;
        wb_if.mem_rsp_data  = rspd;
        err_clr             = clr;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Transaction-level reference model, updated at every rising edge.
    logic              m_armed;
    logic              m_busy;
    int                m_waited;
    logic [ADDR_W-1:0] m_prd;
    logic              m_pwen;
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_err_t;
    logic              m_err_u;

    initial m_armed = 1'b0;

    // Records a register write the way the register file would see it;
    // register 0 never gets written.
    task automatic modelWrite(input logic wen, input logic [ADDR_W-1:0] rd,
                              input logic [DATA_W-1:0] data);
        if (wen && rd != 0) begin
            m_we    = 1'b1;
            m_waddr = rd;
            m_wdata = data;
        end
    endtask

    always @(posedge clk) begin
        logic set_t;
        logic set_u;
        int   src;
        if (!rst_n) begin
            m_armed  = 1'b1;
            m_busy   = 1'b0;
            m_waited = 0;
            m_prd    = '0;
            m_pwen   = 1'b0;
            m_we     = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
            m_err_t  = 1'b0;
            m_err_u  = 1'b0;
        end else if (m_armed) begin
            m_we  = 1'b0;
            set_t = 1'b0;
            set_u = 1'b0;
            if (!m_busy) begin
                if (wb_if.mem_rsp_valid) set_u = 1'b1;
                if (wb_if.in_valid) begin
                    if (int'(wb_if.in_sel) == MEM_SRC) begin
                        m_busy   = 1'b1;
                        m_waited = 0;
                        m_prd    = wb_if.in_rd;
                        m_pwen   = wb_if.in_wen;
                    end else begin
                        src = (int'(wb_if.in_sel) < NUM_SRC) ? int'(wb_if.in_sel) : 0;
                        modelWrite(wb_if.in_wen, wb_if.in_rd,
                                   wb_if.src_data[src*DATA_W +: DATA_W]);
                    end
                end
            end else begin
                m_waited++;
                if (wb_if.mem_rsp_valid) begin
                    modelWrite(m_pwen, m_prd, wb_if.mem_rsp_data);
                    m_busy = 1'b0;
                end else if (m_waited == TIMEOUT) begin
                    m_busy = 1'b0;
                    set_t  = 1'b1;
                end
            end
            m_err_t = set_t | (m_err_t & ~err_clr);
            m_err_u = set_u | (m_err_u & ~err_clr);
        end
    end

    // Per-cycle compare against the model, shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (wb_if.rf_we === 1'b1) write_count++;
        if (m_armed) begin
            checkOutput("model_in_ready", 32'(wb_if.in_ready), 32'(!m_busy));
            checkOutput("model_rf_we", 32'(wb_if.rf_we), 32'(m_we));
            checkOutput("model_err_timeout", 32'(err_timeout), 32'(m_err_t));
            checkOutput("model_err_unexp", 32'(err_unexp_rsp), 32'(m_err_u));
            if (m_we) begin
                checkOutput("model_rf_waddr", 32'(wb_if.rf_waddr), 32'(m_waddr));
                checkOutput("model_rf_wdata", wb_if.rf_wdata, m_wdata);
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int ready_low;
        int writes_before;

        checks      = 0;
        errors      = 0;
        write_count = 0;
        rst_n       = 1'b0;
        err_clr     = 1'b0;
        wb_if.in_valid      = 1'b0;
        wb_if.in_sel        = '0;
        wb_if.in_wen        = 1'b0;
        wb_if.in_rd         = '0;
        wb_if.src_data      = '0;
        wb_if.mem_rsp_valid = 1'b0;
        wb_if.mem_rsp_data  = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rf_we", 32'(wb_if.rf_we), 32'd0);
        checkOutput("reset_rf_waddr", 32'(wb_if.rf_waddr), 32'd0);
        checkOutput("reset_rf_wdata", wb_if.rf_wdata, 32'd0);
        checkOutput("reset_err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("reset_err_unexp", 32'(err_unexp_rsp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_in_ready", 32'(wb_if.in_ready), 32'd1);

        // Three back-to-back ALU results.
        applyStimulus(1'b1, 2'd0, 1'b1, 5'd1, {32'h0, 32'h0, 32'hAAAA_0001}, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1, 5'd2, {32'h0, 32'h0, 32'hBBBB_0002}, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1, 5'd3, {32'h0, 32'h0, 32'hCCCC_0003}, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("b2b_we", 32'(wb_if.rf_we), 32'd1);
        checkOutput("b2b_waddr", 32'(wb_if.rf_waddr), 32'd3);
        checkOutput("b2b_wdata", wb_if.rf_wdata, 32'hCCCC_0003);
        idleCycle();

        // Load to r7, response in the fifth wait cycle.
        ready_low = 0;
        applyStimulus(1'b1, 2'd1, 1'b1, 5'd7, '0, 1'b0, '0, 1'b0);
        repeat (4) begin
            idleCycle();
            if (!wb_if.in_ready) ready_low++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        if (!wb_if.in_ready) ready_low++;
        @(posedge clk);
        #1;
        checkOutput("load_we", 32'(wb_if.rf_we), 32'd1);
        checkOutput("load_waddr", 32'(wb_if.rf_waddr), 32'd7);
        checkOutput("load_wdata", wb_if.rf_wdata, 32'hDEAD_BEEF);
        checkOutput("load_ready_after", 32'(wb_if.in_ready), 32'd1);
        idleCycle();
        checkOutput("load_ready_low_cycles", 32'(ready_low), 32'd5);

        // Load with no response: aborts after eight wait cycles.
        writes_before = write_count;
        applyStimulus(1'b1, 2'd1, 1'b1, 5'd9, '0, 1'b0, '0, 1'b0);
        repeat (8) idleCycle();
        @(posedge clk);
        #1;
        checkOutput("timeout_err", 32'(err_timeout), 32'd1);
        checkOutput("timeout_ready", 32'(wb_if.in_ready), 32'd1);
        checkOutput("timeout_no_write", 32'(write_count - writes_before), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("timeout_err_clr", 32'(err_timeout), 32'd0);
        idleCycle();

        // Response in the abort cycle wins over the timeout.
        applyStimulus(1'b1, 2'd1, 1'b1, 5'd12, '0, 1'b0, '0, 1'b0);
        repeat (7) idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h1234_5678, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("late_rsp_we", 32'(wb_if.rf_we), 32'd1);
        checkOutput("late_rsp_wdata", wb_if.rf_wdata, 32'h1234_5678);
        checkOutput("late_rsp_no_err", 32'(err_timeout), 32'd0);
        idleCycle();

        // Write to r0 is suppressed.
        applyStimulus(1'b1, 2'd0, 1'b1, 5'd0, {32'h0, 32'h0, 32'h5555_5555}, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("zero_reg_we", 32'(wb_if.rf_we), 32'd0);

        // Out-of-range select falls back to source 0.
        applyStimulus(1'b1, 2'd3, 1'b1, 5'd4,
                      {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("sel_oob_wdata", wb_if.rf_wdata, 32'h1111_1111);
        applyStimulus(1'b1, 2'd2, 1'b1, 5'd5,
                      {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("sel2_wdata", wb_if.rf_wdata, 32'h3333_3333);
        idleCycle();

        // Stray response in IDLE, then clear together with a new stray one.
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'hFFFF_0000, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("stray_err", 32'(err_unexp_rsp), 32'd1);
        checkOutput("stray_no_we", 32'(wb_if.rf_we), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'hFFFF_0001, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("clr_vs_set", 32'(err_unexp_rsp), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        idleCycle();

        // Reset while a load is pending, then a late response.
        applyStimulus(1'b1, 2'd1, 1'b1, 5'd6, '0, 1'b0, '0, 1'b0);
        idleCycle();
        idleCycle();
        rst_n = 1'b0;
        idleCycle();
        @(posedge clk);
        #1;
        checkOutput("midrst_we", 32'(wb_if.rf_we), 32'd0);
        checkOutput("midrst_waddr", 32'(wb_if.rf_waddr), 32'd0);
        checkOutput("midrst_wdata", wb_if.rf_wdata, 32'd0);
        checkOutput("midrst_ready", 32'(wb_if.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'hCAFE_F00D, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midrst_late_rsp_err", 32'(err_unexp_rsp), 32'd1);
        checkOutput("midrst_late_rsp_no_we", 32'(wb_if.rf_we), 32'd0);
        idleCycle();
        repeat (2) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
